// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - CPU memory responder: byte RAM, two I/O bytes, serial program loader
module mem_responder #(
  parameter int                DEPTH       = 256,
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] IO_OUT_ADDR = 12'hFF0,
  parameter logic [ADDR_W-1:0] IO_IN_ADDR  = 12'hFF1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] M_addr,
  input  logic [7:0]        M_data_out,
  input  logic              Write_read,
  output logic [7:0]        M_data_in,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_done,
  input  logic              run_start,
  input  logic [7:0]        in_port,
  output logic [7:0]        out_port,
  output logic              cpu_hold,
  output logic [1:0]        state,
  output logic [15:0]       wr_count,
  output logic              addr_err
);

  localparam int                AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [AW-1:0]     LAST_PTR = AW'(DEPTH - 1);

  if (DEPTH < 1 || DEPTH >= 2**ADDR_W || DEPTH > int'(IO_OUT_ADDR) || DEPTH > int'(IO_IN_ADDR)) begin : g_bad_depth
    $error("mem_responder: RAM range overlaps the I/O addresses");
  end

  typedef enum logic [1:0] {
    S_HOLD = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q;
  logic [7:0]    mem [DEPTH];

  logic          run, is_ram, is_out, is_in;
  logic          load_we, cpu_ram_we, wr_ok, bad_access;
  logic [AW-1:0] ram_idx;
  logic [7:0]    rd_byte;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD: begin
        if (load_start)     state_d = S_LOAD;
        else if (run_start) state_d = S_RUN;
      end
      S_LOAD: begin
        // A restart stays in LOAD; otherwise done or the final byte ends the load.
        if (load_start)                                     state_d = S_LOAD;
        else if (load_done || (load_valid && ptr_q == LAST_PTR)) state_d = S_RUN;
      end
      S_RUN: begin
        if (load_start) state_d = S_LOAD;
      end
      default: state_d = S_HOLD;
    endcase
  end

  always_comb begin
    run        = (state_q == S_RUN);
    is_ram     = (M_addr < DEPTH_A);
    is_out     = (M_addr == IO_OUT_ADDR);
    is_in      = (M_addr == IO_IN_ADDR);
    ram_idx    = M_addr[AW-1:0];
    load_we    = !reset && (state_q == S_LOAD) && load_valid && !load_start;
    cpu_ram_we = !reset && run && Write_read && is_ram;
    wr_ok      = run && Write_read && (is_ram || is_out);
    bad_access = run && ((!is_ram && !is_out && !is_in) || (Write_read && is_in));
    rd_byte    = 8'h00;
    if (is_ram)      rd_byte = mem[ram_idx];
    else if (is_in)  rd_byte = in_port;
    else if (is_out) rd_byte = out_port;
  end

  // RAM has no reset so a program survives a reset.
  always_ff @(posedge clk) begin
    if (load_we)         mem[ptr_q]   <= load_data;
    else if (cpu_ram_we) mem[ram_idx] <= M_data_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HOLD;
      ptr_q     <= '0;
      M_data_in <= 8'h00;
      out_port  <= 8'h00;
      wr_count  <= 16'h0000;
      addr_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_start)                         ptr_q <= '0;
      else if (load_we && ptr_q != LAST_PTR)  ptr_q <= ptr_q + 1'b1;
      // Writes also return the old contents so no stale byte lingers.
      if (run)                                M_data_in <= rd_byte;
      if (run && Write_read && is_out)        out_port  <= M_data_out;
      if (wr_ok && wr_count != 16'hFFFF)      wr_count  <= wr_count + 16'd1;
      if (bad_access)                         addr_err  <= 1'b1;
    end
  end

  assign state    = state_q;
  assign cpu_hold = (state_q != S_RUN);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder
module tb_mem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] M_addr;
  logic [7:0]  M_data_out;
  logic        Write_read;
  logic [7:0]  M_data_in;
  logic        load_start, load_valid, load_done, run_start;
  logic [7:0]  load_data, in_port, out_port;
  logic        cpu_hold, addr_err;
  logic [1:0]  state;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [DEPTH];
  logic [7:0] ref_out;
  int         ref_wr;
  logic       ref_err;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .reset(reset), .M_addr(M_addr), .M_data_out(M_data_out),
    .Write_read(Write_read), .M_data_in(M_data_in), .load_start(load_start),
    .load_valid(load_valid), .load_data(load_data), .load_done(load_done),
    .run_start(run_start), .in_port(in_port), .out_port(out_port),
    .cpu_hold(cpu_hold), .state(state), .wr_count(wr_count), .addr_err(addr_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_read(input logic [11:0] a);
    if (a < 12'(DEPTH)) return ref_mem[a[7:0]];
    if (a == 12'hFF1)   return in_port;
    if (a == 12'hFF0)   return ref_out;
    return 8'h00;
  endfunction

  task automatic cpu_op(input logic [11:0] a, input logic wr, input logic [7:0] d, output logic [7:0] exp);
    exp = model_read(a);
    if (wr) begin
      if (a < 12'(DEPTH))    ref_mem[a[7:0]] = d;
      else if (a == 12'hFF0) ref_out = d;
      if ((a < 12'(DEPTH) || a == 12'hFF0) && ref_wr < 65535) ref_wr++;
      if (!(a < 12'(DEPTH) || a == 12'hFF0)) ref_err = 1'b1;
    end else if (!(a < 12'(DEPTH) || a == 12'hFF0 || a == 12'hFF1)) begin
      ref_err = 1'b1;
    end
    M_addr = a; Write_read = wr; M_data_out = d;
    step();
    Write_read = 1'b0; M_addr = 12'h000;
  endtask

  task automatic model_reset();
    ref_out = 8'h00; ref_wr = 0; ref_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    model_reset();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state actual=%0h expected=0", state); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_hold actual=%0b expected=1", cpu_hold); end
    checks++; if (M_data_in !== 8'h00 || out_port !== 8'h00) begin errors++; $display("FAIL reset_data actual=%h/%h expected=00/00", M_data_in, out_port); end
    checks++; if (wr_count !== 16'h0 || addr_err !== 1'b0) begin errors++; $display("FAIL reset_counters actual=%h/%b expected=0/0", wr_count, addr_err); end
  endtask

  task automatic test_load_read();
    logic [7:0] bytes [3];
    logic [7:0] exp;
    bytes[0] = 8'h01; bytes[1] = 8'h22; bytes[2] = 8'h33;
    load_start = 1'b1; run_start = 1'b1; step(); load_start = 1'b0; run_start = 1'b0;
    checks++; if (state !== 2'b01 || cpu_hold !== 1'b1) begin errors++; $display("FAIL load_priority actual=%0h/%b expected=1/1", state, cpu_hold); end
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = bytes[i]; ref_mem[i] = bytes[i]; step();
    end
    load_valid = 1'b0; load_done = 1'b1; step(); load_done = 1'b0;
    checks++; if (state !== 2'b10 || cpu_hold !== 1'b0) begin errors++; $display("FAIL load_done_run actual=%0h/%b expected=2/0", state, cpu_hold); end
    for (int i = 0; i < 3; i++) begin
      cpu_op(12'(i), 1'b0, 8'h00, exp);
      checks++; if (M_data_in !== bytes[i]) begin errors++; $display("FAIL load_readback[%0d] actual=%h expected=%h", i, M_data_in, bytes[i]); end
    end
  endtask

  task automatic test_ram_write();
    logic [7:0] exp;
    cpu_op(12'h010, 1'b1, 8'hA5, exp);
    cpu_op(12'h010, 1'b0, 8'h00, exp);
    checks++; if (M_data_in !== 8'hA5) begin errors++; $display("FAIL ram_write_read actual=%h expected=a5", M_data_in); end
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL ram_wr_count actual=%0d expected=1", wr_count); end
    cpu_op(12'h001, 1'b1, 8'h77, exp);
    checks++; if (M_data_in !== 8'h22) begin errors++; $display("FAIL read_before_write actual=%h expected=22", M_data_in); end
  endtask

  task automatic test_io();
    logic [7:0] exp;
    cpu_op(12'hFF0, 1'b1, 8'h5A, exp);
    checks++; if (out_port !== 8'h5A) begin errors++; $display("FAIL out_port actual=%h expected=5a", out_port); end
    in_port = 8'h3C;
    cpu_op(12'hFF1, 1'b0, 8'h00, exp);
    checks++; if (M_data_in !== 8'h3C) begin errors++; $display("FAIL in_port_read actual=%h expected=3c", M_data_in); end
    cpu_op(12'hFF0, 1'b0, 8'h00, exp);
    checks++; if (M_data_in !== 8'h5A) begin errors++; $display("FAIL out_port_read actual=%h expected=5a", M_data_in); end
    checks++; if (wr_count !== 16'(ref_wr)) begin errors++; $display("FAIL io_wr_count actual=%0d expected=%0d", wr_count, ref_wr); end
  endtask

  task automatic test_addr_err();
    logic [7:0] exp;
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_before actual=%b expected=0", addr_err); end
    cpu_op(12'h800, 1'b0, 8'h00, exp);
    checks++; if (M_data_in !== 8'h00 || addr_err !== 1'b1) begin errors++; $display("FAIL unmapped_read actual=%h/%b expected=00/1", M_data_in, addr_err); end
    cpu_op(12'hFF1, 1'b1, 8'h99, exp);
    checks++; if (wr_count !== 16'(ref_wr) || addr_err !== 1'b1) begin errors++; $display("FAIL in_port_write actual=%0d/%b expected=%0d/1", wr_count, addr_err, ref_wr); end
  endtask

  task automatic test_full_load();
    logic [7:0] exp, d;
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom); load_valid = 1'b1; load_data = d; ref_mem[i] = d; step();
      if (i == DEPTH - 2) begin
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL full_load_early actual=%0h expected=1", state); end
      end
    end
    load_valid = 1'b0;
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL auto_finish actual=%0h expected=2", state); end
    cpu_op(12'h0FF, 1'b0, 8'h00, exp);
    checks++; if (M_data_in !== exp) begin errors++; $display("FAIL last_byte actual=%h expected=%h", M_data_in, exp); end
    cpu_op(12'h000, 1'b0, 8'h00, exp);
    checks++; if (M_data_in !== exp) begin errors++; $display("FAIL first_byte actual=%h expected=%h", M_data_in, exp); end
  endtask

  task automatic test_load_done_same();
    logic [7:0] exp, d;
    load_start = 1'b1; step(); load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'hAA; step(); load_data = 8'hBB; step();
    load_start = 1'b1; load_data = 8'hCC; step(); load_start = 1'b0;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL restart_state actual=%0h expected=1", state); end
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom); load_data = d; ref_mem[i] = d;
      load_done = (i == 3);
      step();
    end
    load_valid = 1'b0; load_done = 1'b0;
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL valid_and_done actual=%0h expected=2", state); end
    for (int i = 0; i < 5; i++) begin
      cpu_op(12'(i), 1'b0, 8'h00, exp);
      checks++; if (M_data_in !== exp) begin errors++; $display("FAIL restart_read[%0d] actual=%h expected=%h", i, M_data_in, exp); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  exp;
    logic [11:0] a;
    logic        wr;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 12'hFF0;
        1:       a = 12'hFF1;
        2:       a = 12'($urandom_range(DEPTH, 12'hFEF));
        default: a = 12'($urandom_range(0, DEPTH - 1));
      endcase
      wr = 1'($urandom);
      in_port = 8'($urandom);
      cpu_op(a, wr, 8'($urandom), exp);
      checks++;
      if (M_data_in !== exp || out_port !== ref_out || wr_count !== 16'(ref_wr) || addr_err !== ref_err) begin
        errors++;
        $display("FAIL random[%0d] addr=%h wr=%b actual=%h/%h/%0d/%b expected=%h/%h/%0d/%b",
                 n, a, wr, M_data_in, out_port, wr_count, addr_err, exp, ref_out, ref_wr, ref_err);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] exp, d;
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom); load_valid = 1'b1; load_data = d; ref_mem[i] = d; step();
    end
    load_data = 8'hEE; reset = 1'b1; step(); reset = 1'b0; load_valid = 1'b0;
    model_reset();
    checks++; if (state !== 2'b00 || cpu_hold !== 1'b1) begin errors++; $display("FAIL midload_reset actual=%0h/%b expected=0/1", state, cpu_hold); end
    checks++; if (out_port !== 8'h00 || wr_count !== 16'h0) begin errors++; $display("FAIL midload_regs actual=%h/%0d expected=00/0", out_port, wr_count); end
    M_addr = 12'h000; Write_read = 1'b1; M_data_out = 8'hEE; step(); Write_read = 1'b0;
    checks++; if (wr_count !== 16'h0 || M_data_in !== 8'h00) begin errors++; $display("FAIL hold_ignores_cpu actual=%0d/%h expected=0/00", wr_count, M_data_in); end
    run_start = 1'b1; step(); run_start = 1'b0;
    checks++; if (state !== 2'b10 || cpu_hold !== 1'b0) begin errors++; $display("FAIL run_start actual=%0h/%b expected=2/0", state, cpu_hold); end
    for (int i = 0; i < 5; i++) begin
      cpu_op(12'(i), 1'b0, 8'h00, exp);
      checks++; if (M_data_in !== exp) begin errors++; $display("FAIL kept_byte[%0d] actual=%h expected=%h", i, M_data_in, exp); end
    end
  endtask

  initial begin
    reset = 1'b0; M_addr = 12'h000; M_data_out = 8'h00; Write_read = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_done = 1'b0;
    run_start = 1'b0; in_port = 8'h00;
    test_reset();
    test_load_read();
    test_ram_write();
    test_io();
    test_addr_err();
    test_full_load();
    test_load_done_same();
    test_random();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
